// File: rtl/tty_pkg.sv
// -----------------------------------------------------------------------------
// tty_pkg
// Shared definitions for the buffered TTY output port:
//   - tty_state_e : controller state encoding
//   - ASCII_CR/LF : control characters used by the optional CR/LF expansion
//   - cnt_width() : width of an occupancy counter that can hold 0..depth
// Optional feature macro: TTY_CRLF_EXPAND_EN (adds the ST_SEND_LF state).
// -----------------------------------------------------------------------------
package tty_pkg;

`ifdef TTY_CRLF_EXPAND_EN
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEND    = 3'd1,
      ST_GAP     = 3'd2,
      ST_CLEAR   = 3'd3,
      ST_SEND_LF = 3'd4
   } tty_state_e;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEND  = 3'd1,
      ST_GAP   = 3'd2,
      ST_CLEAR = 3'd3
   } tty_state_e;
`endif

   localparam logic [6:0] ASCII_CR = 7'h0D;
   localparam logic [6:0] ASCII_LF = 7'h0A;

   // Counter must represent "depth" itself, hence depth+1 codes.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/tty_out_buffer_if.sv
// -----------------------------------------------------------------------------
// tty_out_buffer_if
// Bundles the core-side write port and the TTY-side strobe port.
//   slave  : the buffer (receives wr_en/wr_data/clr_req/TTY_ready)
//   master : the environment (core + TTY device)
// Signals: wr_en, wr_data, clr_req, full, count, overflow, busy,
//          TTY_ready, TTY_data, TTY_en, TTY_clear.
// -----------------------------------------------------------------------------
interface tty_out_buffer_if #(
   parameter int DATA_W = 7,
   parameter int DEPTH  = 16
);
   import tty_pkg::*;

   localparam int CNT_W = cnt_width(DEPTH);

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              clr_req;
   logic              full;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              busy;
   logic              TTY_ready;
   logic [DATA_W-1:0] TTY_data;
   logic              TTY_en;
   logic              TTY_clear;

   modport slave (
      input  wr_en, wr_data, clr_req, TTY_ready,
      output full, count, overflow, busy, TTY_data, TTY_en, TTY_clear
   );

   modport master (
      output wr_en, wr_data, clr_req, TTY_ready,
      input  full, count, overflow, busy, TTY_data, TTY_en, TTY_clear
   );

endinterface

// File: rtl/tty_sync_fifo.sv
// -----------------------------------------------------------------------------
// tty_sync_fifo
// Single-clock FIFO with registered read data and a synchronous flush.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : write i_wr_data (ignored when full or flushing)
//   i_pop       : load head into o_rd_data (ignored when empty or flushing)
//   i_flush     : empty the FIFO; o_rd_data keeps its last value
//   o_rd_data   : last popped entry (registered)
//   o_count     : entries held
//   o_full      : registered, count == DEPTH
//   o_empty     : count == 0
// -----------------------------------------------------------------------------
module tty_sync_fifo
   import tty_pkg::*;
#(
   parameter int DATA_W = 7,
   parameter int DEPTH  = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_push,
   input  logic [DATA_W-1:0]            i_wr_data,
   input  logic                         i_pop,
   input  logic                         i_flush,
   output logic [DATA_W-1:0]            o_rd_data,
   output logic [cnt_width(DEPTH)-1:0]  o_count,
   output logic                         o_full,
   output logic                         o_empty
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = cnt_width(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_full;
   logic [DATA_W-1:0] r_rd_data;

   logic              w_do_push;
   logic              w_do_pop;
   logic [CNT_W-1:0]  w_count_next;

   assign w_do_push = i_push && !r_full && !i_flush;
   assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_count_next = r_count;
      if (w_do_push && !w_do_pop) begin
         w_count_next = r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
         w_count_next = r_count - CNT_W'(1);
      end
   end

   // NOTE: the storage array is not reset; pointers and count alone define valid entries.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_full    <= 1'b0;
         r_rd_data <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_data <= r_mem[r_rd_ptr];
            r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
         end
         r_count <= w_count_next;
         r_full  <= (w_count_next == CNT_W'(DEPTH));
      end
   end

   assign o_rd_data = r_rd_data;
   assign o_count   = r_count;
   assign o_full    = r_full;
   assign o_empty   = (r_count == '0);

endmodule

// File: rtl/tty_out_buffer.sv
// -----------------------------------------------------------------------------
// tty_out_buffer
// Buffered TTY output port: characters from the core are queued in a FIFO and
// drained to the TTY one strobe at a time, each strobe followed by GAP_CYCLES
// idle cycles. Also sequences a screen clear and flags overflow.
// Ports:
//   mclk   : clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : tty_out_buffer_if.slave (core write port + TTY strobe port)
// Parameters: DATA_W (char width), DEPTH (power of two, >= 2),
//             GAP_CYCLES (>= 1).
// Optional feature macro: TTY_CRLF_EXPAND_EN -- a popped LF is emitted as CR
// followed by LF, each with its own strobe and gap.
// -----------------------------------------------------------------------------
module tty_out_buffer
   import tty_pkg::*;
#(
   parameter int DATA_W     = 7,
   parameter int DEPTH      = 16,
   parameter int GAP_CYCLES = 2
) (
   input  logic            mclk,
   input  logic            reset,
   tty_out_buffer_if.slave bus
);

   localparam int CNT_W = cnt_width(DEPTH);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   localparam logic [2:0] S_IDLE    = ST_IDLE;
   localparam logic [2:0] S_SEND    = ST_SEND;
   localparam logic [2:0] S_GAP     = ST_GAP;
   localparam logic [2:0] S_CLEAR   = ST_CLEAR;
`ifdef TTY_CRLF_EXPAND_EN
   localparam logic [2:0] S_SEND_LF = ST_SEND_LF;
`endif

   logic [2:0]        r_state;
   logic [GAP_W-1:0]  r_gap_cnt;
   logic              r_clr_fire;   // CLEAR has seen TTY_ready; strobe this cycle
   logic              r_overflow;

   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic              w_flush;
   logic              w_gap_done;
   logic [2:0]        w_gap_exit;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [CNT_W-1:0]  w_count;
   logic [DATA_W-1:0] w_fifo_rd;
   logic [DATA_W-1:0] w_tty_data;
   logic              w_tty_en;

   // CLEAR blocks writes just like a full FIFO does.
   assign w_full     = w_fifo_full || (r_state == S_CLEAR);
   assign w_push     = bus.wr_en && !w_full;
   assign w_flush    = bus.clr_req && (r_state != S_CLEAR);
   assign w_pop      = (r_state == S_IDLE) && !bus.clr_req && !w_fifo_empty && bus.TTY_ready;
   assign w_gap_done = (r_state == S_GAP) && (r_gap_cnt <= GAP_W'(1));

   tty_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (mclk),
      .rst_n     (reset),
      .i_push    (w_push),
      .i_wr_data (bus.wr_data),
      .i_pop     (w_pop),
      .i_flush   (w_flush),
      .o_rd_data (w_fifo_rd),
      .o_count   (w_count),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty)
   );

`ifdef TTY_CRLF_EXPAND_EN
   logic r_cr_phase;    // popped char not yet advanced to its LF half
   logic r_lf_pending;  // CR went out; LF strobe still owed
   logic w_is_lf;
   logic w_enter_lf;

   assign w_is_lf    = (w_fifo_rd == DATA_W'(ASCII_LF));
   assign w_enter_lf = w_gap_done && !w_flush && r_lf_pending;
   assign w_gap_exit = r_lf_pending ? S_SEND_LF : S_IDLE;
   assign w_tty_data = (r_cr_phase && w_is_lf) ? DATA_W'(ASCII_CR) : w_fifo_rd;
   assign w_tty_en   = (r_state == S_SEND) || (r_state == S_SEND_LF);

   // A clear abandons the owed LF but leaves r_cr_phase alone so TTY_data
   // keeps showing CR until the next pop.
   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         r_cr_phase   <= 1'b0;
         r_lf_pending <= 1'b0;
      end else begin
         if (w_pop) begin
            r_cr_phase <= 1'b1;
         end else if (w_enter_lf) begin
            r_cr_phase <= 1'b0;
         end
         if (w_flush) begin
            r_lf_pending <= 1'b0;
         end else if (r_state == S_SEND) begin
            r_lf_pending <= w_is_lf;
         end else if (w_enter_lf) begin
            r_lf_pending <= 1'b0;
         end
      end
   end
`else
   assign w_gap_exit = S_IDLE;
   assign w_tty_data = w_fifo_rd;
   assign w_tty_en   = (r_state == S_SEND);
`endif

   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_gap_cnt  <= '0;
         r_clr_fire <= 1'b0;
      end else if (w_flush) begin
         // A strobe issued this cycle is already complete; only queued data is lost.
         r_state    <= S_CLEAR;
         r_clr_fire <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_state <= S_SEND;
               end
            end
            S_SEND: begin
               r_state   <= S_GAP;
               r_gap_cnt <= GAP_W'(GAP_CYCLES);
            end
`ifdef TTY_CRLF_EXPAND_EN
            S_SEND_LF: begin
               r_state   <= S_GAP;
               r_gap_cnt <= GAP_W'(GAP_CYCLES);
            end
`endif
            S_GAP: begin
               r_gap_cnt <= r_gap_cnt - GAP_W'(1);
               if (w_gap_done) begin
                  r_state <= w_gap_exit;
               end
            end
            S_CLEAR: begin
               // Two phases: wait for TTY_ready, then one strobe cycle.
               if (r_clr_fire) begin
                  r_clr_fire <= 1'b0;
                  r_state    <= S_GAP;
                  r_gap_cnt  <= GAP_W'(GAP_CYCLES);
               end else if (bus.TTY_ready) begin
                  r_clr_fire <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         r_overflow <= 1'b0;
      end else if (bus.wr_en && w_full) begin
         r_overflow <= 1'b1;
      end
   end

   assign bus.full      = w_full;
   assign bus.count     = w_count;
   assign bus.overflow  = r_overflow;
   assign bus.busy      = (r_state != S_IDLE) || !w_fifo_empty;
   assign bus.TTY_data  = w_tty_data;
   assign bus.TTY_en    = w_tty_en;
   assign bus.TTY_clear = (r_state == S_CLEAR) && r_clr_fire;

endmodule

// File: tb/tb_tty_out_buffer.sv
// -----------------------------------------------------------------------------
// tb_tty_out_buffer
// Directed bench for tty_out_buffer (DATA_W=7, DEPTH=16, GAP_CYCLES=2).
// Inputs are driven and outputs sampled on the falling edge of mclk.
// Honours TTY_CRLF_EXPAND_EN for the LF scenario.
// -----------------------------------------------------------------------------
module tb_tty_out_buffer;
   import tty_pkg::*;

   localparam int DATA_W     = 7;
   localparam int DEPTH      = 16;
   localparam int GAP_CYCLES = 2;

   logic mclk  = 1'b0;
   logic reset = 1'b0;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   strobes;
   int   ens;
   int   clears;
   int   hits;
   int   first;
   int   second;
   logic [DATA_W-1:0] d0;
   logic [DATA_W-1:0] d1;

   tty_out_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   tty_out_buffer #(
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .mclk  (mclk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 mclk = ~mclk;

   task automatic tick();
      @(posedge mclk);
      @(negedge mclk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.wr_en     = 1'b0;
      bus.wr_data   = '0;
      bus.clr_req   = 1'b0;
      bus.TTY_ready = 1'b0;

      // ---------------- reset state ----------------
      repeat (2) @(negedge mclk);
      check("rst_tty_data", bus.TTY_data, 0);
      check("rst_tty_en", bus.TTY_en, 0);
      check("rst_tty_clear", bus.TTY_clear, 0);
      check("rst_full", bus.full, 0);
      check("rst_count", bus.count, 0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_busy", bus.busy, 0);
      reset = 1'b1;
      tick();

      // ---------------- 1: 'H','i' back to back ----------------
      bus.TTY_ready = 1'b1;
      bus.wr_en     = 1'b1;
      bus.wr_data   = 7'h48;
      tick();                                   // cycle 1
      check("t1_c1_en", bus.TTY_en, 0);
      check("t1_c1_count", bus.count, 1);
      bus.wr_data = 7'h69;
      tick();                                   // cycle 2: strobe 'H'
      check("t1_c2_en", bus.TTY_en, 1);
      check("t1_c2_data", bus.TTY_data, 32'h48);
      check("t1_c2_count", bus.count, 1);
      bus.wr_en = 1'b0;
      tick();
      check("t1_c3_en", bus.TTY_en, 0);
      tick();
      check("t1_c4_en", bus.TTY_en, 0);
      check("t1_c4_hold", bus.TTY_data, 32'h48);
      tick();
      check("t1_c5_en", bus.TTY_en, 0);
      check("t1_c5_busy", bus.busy, 1);
      tick();                                   // cycle 6: strobe 'i'
      check("t1_c6_en", bus.TTY_en, 1);
      check("t1_c6_data", bus.TTY_data, 32'h69);
      check("t1_c6_count", bus.count, 0);
      tick();
      check("t1_c7_en", bus.TTY_en, 0);
      tick();
      check("t1_c8_busy", bus.busy, 1);
      tick();
      check("t1_c9_busy", bus.busy, 0);

      // ---------------- 2: fill to full, overflow, drain ----------------
      bus.TTY_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_data = DATA_W'(8'h30 + i);
         tick();
         if (i == 14) begin
            check("t2_full_at_15", bus.full, 0);
            check("t2_count_at_15", bus.count, 15);
         end
      end
      check("t2_full_at_16", bus.full, 1);
      check("t2_count_at_16", bus.count, 16);
      check("t2_ovf_at_16", bus.overflow, 0);
      bus.wr_data = 7'h40;
      tick();
      bus.wr_en = 1'b0;
      check("t2_ovf_at_17", bus.overflow, 1);
      check("t2_count_at_17", bus.count, 16);
      bus.TTY_ready = 1'b1;
      strobes = 0;
      for (int c = 0; c < 72; c++) begin
         tick();
         if (bus.TTY_en) begin
            if (strobes < 16) check($sformatf("t2_data_%0d", strobes), bus.TTY_data, 32'h30 + strobes);
            strobes++;
         end
      end
      check("t2_strobes", strobes, 16);
      check("t2_count_end", bus.count, 0);
      check("t2_busy_end", bus.busy, 0);
      check("t2_ovf_sticky", bus.overflow, 1);
      check("t2_full_end", bus.full, 0);

      // ---------------- 3: clear during GAP ----------------
      bus.TTY_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_data = DATA_W'(8'h61 + i);
         tick();
      end
      bus.wr_en = 1'b0;
      check("t3_loaded", bus.count, 5);
      bus.TTY_ready = 1'b1;
      tick();
      check("t3_send_en", bus.TTY_en, 1);
      check("t3_send_data", bus.TTY_data, 32'h61);
      check("t3_send_count", bus.count, 4);
      bus.TTY_ready = 1'b0;
      tick();
      check("t3_gap_en", bus.TTY_en, 0);
      bus.clr_req = 1'b1;
      tick();
      bus.clr_req = 1'b0;
      check("t3_flush_count", bus.count, 0);
      check("t3_clear_full", bus.full, 1);
      tick();
      tick();
      check("t3_wait_clear", bus.TTY_clear, 0);
      check("t3_wait_busy", bus.busy, 1);
      bus.TTY_ready = 1'b1;
      ens    = 0;
      clears = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (c == 0) check("t3_clear_strobe", bus.TTY_clear, 1);
         if (bus.TTY_clear) clears++;
         if (bus.TTY_en) ens++;
      end
      check("t3_clears", clears, 1);
      check("t3_no_en", ens, 0);
      check("t3_full_after", bus.full, 0);
      check("t3_busy_after", bus.busy, 0);

      // ---------------- 5: reset during SEND ----------------
      bus.wr_en   = 1'b1;
      bus.wr_data = 7'h5A;
      tick();
      bus.wr_en = 1'b0;
      tick();
      check("t5_send_en", bus.TTY_en, 1);
      check("t5_send_data", bus.TTY_data, 32'h5A);
      #2 reset = 1'b0;
      #1;
      check("t5_rst_en", bus.TTY_en, 0);
      check("t5_rst_count", bus.count, 0);
      check("t5_rst_ovf", bus.overflow, 0);
      check("t5_rst_data", bus.TTY_data, 0);
      check("t5_rst_busy", bus.busy, 0);
      @(negedge mclk);
      reset = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_data = 7'h41;
      tick();
      bus.wr_en = 1'b0;
      check("t5_a_count", bus.count, 1);
      tick();
      check("t5_a_en", bus.TTY_en, 1);
      check("t5_a_data", bus.TTY_data, 32'h41);
      repeat (4) tick();
      check("t5_a_idle", bus.busy, 0);

      // ---------------- 4: write during CLEAR ----------------
      bus.TTY_ready = 1'b0;
      bus.clr_req   = 1'b1;
      tick();
      bus.clr_req = 1'b0;
      check("t4_full", bus.full, 1);
      check("t4_ovf_before", bus.overflow, 0);
      bus.wr_en   = 1'b1;
      bus.wr_data = 7'h51;
      tick();
      bus.wr_en = 1'b0;
      check("t4_ovf", bus.overflow, 1);
      check("t4_count", bus.count, 0);
      bus.clr_req = 1'b1;                       // ignored while already clearing
      tick();
      bus.clr_req = 1'b0;
      check("t4_still_full", bus.full, 1);
      bus.TTY_ready = 1'b1;
      ens    = 0;
      clears = 0;
      hits   = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (bus.TTY_clear) clears++;
         if (bus.TTY_en) ens++;
         if (bus.TTY_data == 7'h51) hits++;
      end
      check("t4_clears", clears, 1);
      check("t4_no_en", ens, 0);
      check("t4_no_q", hits, 0);
      check("t4_data_held", bus.TTY_data, 32'h41);

      // ---------------- 6: line feed ----------------
      bus.wr_en   = 1'b1;
      bus.wr_data = 7'h0A;
      tick();
      bus.wr_en = 1'b0;
      ens    = 0;
      first  = -1;
      second = -1;
      d0     = '0;
      d1     = '0;
      for (int c = 0; c < 14; c++) begin
         tick();
         if (bus.TTY_en) begin
            if (ens == 0) begin
               first = c;
               d0    = bus.TTY_data;
            end else begin
               second = c;
               d1     = bus.TTY_data;
            end
            ens++;
         end
      end
      check("t6_first_at", first, 0);
`ifdef TTY_CRLF_EXPAND_EN
      check("t6_strobes", ens, 2);
      check("t6_cr", d0, 32'h0D);
      check("t6_lf", d1, 32'h0A);
      check("t6_spacing", second - first, GAP_CYCLES + 1);
`else
      check("t6_strobes", ens, 1);
      check("t6_lf", d0, 32'h0A);
      check("t6_no_second", second, -1);
`endif
      check("t6_idle", bus.busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
